rgb_strip_driver: RTL and testbench
===================================

RGB_STRIP_DRIVER -- requirements
Module: rgb_strip_driver

Interface
REQ-001 SHALL have parameter N_LED, default 4, giving the number of sampled lines and LEDs driven (range 1..16).
REQ-002 SHALL have parameter LINES_PER_FRAME, default 750, giving the number of H_sync pulses per frame.
REQ-003 SHALL have parameter FIRST_LINE, default 115, giving the line index of the LED 0 sample.
REQ-004 SHALL have parameter LINE_STEP, default 180, giving the line spacing between successive LED samples.
REQ-005 SHALL have port clk_10MHz  input  1  sole clock, 10 MHz, all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port H_sync  input  1  asynchronous line-sync pulse; rising edge = new line.
REQ-008 SHALL have port rgb_data  input  24  pixel value, R[23:16] G[15:8] B[7:0], valid at H_sync rising edge.
REQ-009 SHALL have port bright_shift  input  3  global dimming; each colour is right-shifted by this amount before transmission.
REQ-010 SHALL have port rgb_led  output  1  SK6805 serial data line.
REQ-011 SHALL have port busy  output  1  high while a strip update (bits + latch) is in progress.
REQ-012 SHALL have port frame_drop  output  1  one-cycle pulse when a completed frame is discarded.

Function
REQ-013 SHALL synchronise H_sync through two flip-flops and detect the rising edge on the synchronised signal; one edge = one line event.
REQ-014 SHALL register rgb_data in the line-event cycle, so capture is 2-3 clk after the raw edge.
REQ-015 SHALL keep a line counter 0..LINES_PER_FRAME-1 that increments on each line event and wraps from LINES_PER_FRAME-1 to 0.
REQ-016 SHALL, on a line event with counter == FIRST_LINE + k*LINE_STEP (k < N_LED), store the captured pixel into shadow entry k; other lines store nothing.
REQ-017 SHALL raise an internal frame_done in the line event that wraps the counter to 0.
REQ-018 SHALL, on frame_done with the serializer in IDLE, copy all N_LED shadow entries into the transmit buffer in one cycle and start transmission.
REQ-019 SHALL, on frame_done while busy, leave the transmit buffer unchanged, pulse frame_drop for 1 cycle, and keep filling the shadow entries.
REQ-020 SHALL implement a serializer FSM with states IDLE, LOAD, BIT_HIGH, BIT_LOW, LATCH.
REQ-021 SHALL make the transitions IDLE->LOAD on frame_done, LOAD->BIT_HIGH, BIT_HIGH->BIT_LOW, BIT_LOW->BIT_HIGH (bits remain) or BIT_LOW->LATCH (last bit), and LATCH->IDLE.
REQ-022 SHALL send LED 0 first; each LED is 24 bits in GRB order, MSB first, colours being (value >> bright_shift) as sampled in LOAD.
REQ-023 SHALL use bit timing: 0-bit = 3 cycles high then 9 cycles low; 1-bit = 6 cycles high then 6 cycles low; 12 cycles per bit, 288 per LED.
REQ-024 SHALL hold rgb_led low for 800 cycles (80 us) in LATCH.
REQ-025 SHALL raise rgb_led for the first bit exactly 2 cycles after the frame_done cycle.
REQ-026 SHALL assert busy in every state except IDLE; busy SHALL fall in the cycle IDLE is re-entered.
REQ-027 SHALL, if frame_done and a line event sampling k=0 coincide (FIRST_LINE = 0), copy the old shadow first and then write the new sample.

Reset
REQ-028 SHALL, with rst high at a clock edge, clear the line counter, shadow, transmit buffer and sync flops to 0, set the FSM to IDLE, and drive rgb_led=0, busy=0, frame_drop=0.
REQ-029 SHALL, on reset mid-transmission, abort immediately (rgb_led low the next cycle) and send no partial frame after release.

Structure
REQ-030 SHALL put the SK6805 timing constants (T0H=3, T1H=6, TBIT=12, TLATCH=800) and the FSM state typedef in shared package sk6805_pkg.
REQ-031 SHALL build the serializer (FSM, bit/LED counters, brightness shift) as sub-module sk6805_serializer; line sampling and buffering stay in the top.

Verification
REQ-032 SHALL verify single frame: N_LED=4, line pixels 0xFF0000/0x00FF00/0x0000FF/0x0F0F0F at lines 115/295/475/655, 750 H_sync pulses -> 96 bits decoded as GRB 00FF00, FF0000, 0000FF, 0F0F0F; then 800-cycle low; busy drops.
REQ-033 SHALL verify bit timing: pixel 0x800000 -> first G bits 3H/9L; R MSB 6H/6L; every period 12 cycles.
REQ-034 SHALL verify brightness: bright_shift=4, pixel 0xF0F0F0 -> each colour transmits 0x0F.
REQ-035 SHALL verify overrun: H_sync period so short that a second frame ends during transmission -> frame_drop 1-cycle pulse, transmitted data unchanged.
REQ-036 SHALL verify reset mid-frame: rst high at bit 40 -> rgb_led=0 and busy=0 the next cycle; line counter restarts at 0.
REQ-037 SHALL verify parameters: N_LED=1, LINES_PER_FRAME=10, FIRST_LINE=3 -> 24 bits sent per frame, line-3 pixel only.

Source files
------------

// File: rtl/sk6805_pkg.sv
// SK6805 waveform timing constants, serializer state encoding and colour helper
// shared by the strip driver and its serializer.
package sk6805_pkg;

    localparam int T0H    = 3;
    localparam int T1H    = 6;
    localparam int TBIT   = 12;
    localparam int TLATCH = 800;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BIT_HIGH,
        BIT_LOW,
        LATCH
    } ser_state_t;

    // Reorder an RGB pixel into the GRB wire order, dimming each channel.
    function automatic logic [23:0] grb_dim(input logic [23:0] rgb, input logic [2:0] sh);
        logic [7:0] r, g, b;
        r = rgb[23:16] >> sh;
        g = rgb[15:8] >> sh;
        b = rgb[7:0] >> sh;
        return {g, r, b};
    endfunction

endpackage

// File: rtl/sk6805_serializer.sv
// Shifts N_LED pixels out as SK6805 NRZ pulses (LED 0 first, GRB, MSB first)
// followed by the latch gap.
module sk6805_serializer
    import sk6805_pkg::*;
#(
    parameter int N_LED = 4
) (
    input  logic                 clk_10MHz,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_LED*24-1:0]  tx_data,
    input  logic [2:0]           bright_shift,
    output logic                 rgb_led,
    output logic                 busy
);

    ser_state_t  state;
    logic [23:0] shreg;
    logic [2:0]  shift_q;
    logic [4:0]  bit_idx;
    logic [4:0]  led_idx;
    logic [9:0]  cnt;
    logic [9:0]  hi_end;
    logic [9:0]  lo_end;

    // Pulse split of the bit currently on the wire (shreg[23]).
    assign hi_end = shreg[23] ? 10'(T1H - 1) : 10'(T0H - 1);
    assign lo_end = shreg[23] ? 10'(TBIT - T1H - 1) : 10'(TBIT - T0H - 1);

    always_ff @(posedge clk_10MHz) begin
        if (rst) begin
            state   <= IDLE;
            rgb_led <= 1'b0;
            busy    <= 1'b0;
            shreg   <= '0;
            shift_q <= '0;
            bit_idx <= '0;
            led_idx <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    shift_q <= bright_shift;
                    shreg   <= grb_dim(tx_data[23:0], bright_shift);
                    bit_idx <= '0;
                    led_idx <= '0;
                    cnt     <= '0;
                    rgb_led <= 1'b1;
                    state   <= BIT_HIGH;
                end
                BIT_HIGH: begin
                    if (cnt == hi_end) begin
                        cnt     <= '0;
                        rgb_led <= 1'b0;
                        state   <= BIT_LOW;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                BIT_LOW: begin
                    if (cnt == lo_end) begin
                        cnt <= '0;
                        if (bit_idx == 5'd23) begin
                            if (led_idx == 5'(N_LED - 1)) begin
                                state <= LATCH;
                            end else begin
                                led_idx <= led_idx + 5'd1;
                                bit_idx <= '0;
                                shreg   <= grb_dim(tx_data[(int'(led_idx) + 1)*24 +: 24], shift_q);
                                rgb_led <= 1'b1;
                                state   <= BIT_HIGH;
                            end
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                            shreg   <= {shreg[22:0], 1'b0};
                            rgb_led <= 1'b1;
                            state   <= BIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                LATCH: begin
                    if (cnt == 10'(TLATCH - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    rgb_led <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rgb_strip_driver.sv
// Samples one pixel per LED from chosen video lines and pushes the frame's
// samples to an SK6805 strip once per frame.
module rgb_strip_driver
    import sk6805_pkg::*;
#(
    parameter int N_LED           = 4,
    parameter int LINES_PER_FRAME = 750,
    parameter int FIRST_LINE      = 115,
    parameter int LINE_STEP       = 180
) (
    input  logic        clk_10MHz,
    input  logic        rst,
    input  logic        H_sync,
    input  logic [23:0] rgb_data,
    input  logic [2:0]  bright_shift,
    output logic        rgb_led,
    output logic        busy,
    output logic        frame_drop
);

    localparam int LCW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

    logic                 hs_s1, hs_s2, hs_s3;
    logic                 line_ev;
    logic                 frame_done;
    logic                 start;
    logic [LCW-1:0]       line_cnt;
    logic [N_LED*24-1:0]  shadow;
    logic [N_LED*24-1:0]  tx_buf;

    assign line_ev    = hs_s2 & ~hs_s3;
    assign frame_done = line_ev && (line_cnt == LCW'(LINES_PER_FRAME - 1));
    assign start      = frame_done && !busy;

    // Shadow keeps filling while a frame is on the wire; tx_buf only changes
    // when the serializer accepts a new frame. Non-blocking updates mean a
    // same-cycle copy sees the old shadow contents.
    always_ff @(posedge clk_10MHz) begin
        if (rst) begin
            hs_s1      <= 1'b0;
            hs_s2      <= 1'b0;
            hs_s3      <= 1'b0;
            line_cnt   <= '0;
            shadow     <= '0;
            tx_buf     <= '0;
            frame_drop <= 1'b0;
        end else begin
            hs_s1      <= H_sync;
            hs_s2      <= hs_s1;
            hs_s3      <= hs_s2;
            frame_drop <= frame_done && busy;
            if (line_ev) begin
                line_cnt <= frame_done ? '0 : line_cnt + LCW'(1);
                for (int k = 0; k < N_LED; k++) begin
                    if (int'(line_cnt) == FIRST_LINE + k*LINE_STEP)
                        shadow[k*24 +: 24] <= rgb_data;
                end
            end
            if (start)
                tx_buf <= shadow;
        end
    end

    sk6805_serializer #(.N_LED(N_LED)) u_ser (
        .clk_10MHz    (clk_10MHz),
        .rst          (rst),
        .start        (start),
        .tx_data      (tx_buf),
        .bright_shift (bright_shift),
        .rgb_led      (rgb_led),
        .busy         (busy)
    );

endmodule

// File: tb/tb_rgb_strip_driver.sv
// Directed bench for rgb_strip_driver: default-parameter strip plus a
// one-LED, ten-line instance; the waveform is decoded from pulse widths.
module tb_rgb_strip_driver;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic        rst0, hs0, led0, busy0, fd0;
    logic [23:0] rgb0;
    logic [2:0]  br0;
    logic        rst1, hs1, led1, busy1, fd1;
    logic [23:0] rgb1;
    logic [2:0]  br1;

    rgb_strip_driver dut0 (
        .clk_10MHz(clk), .rst(rst0), .H_sync(hs0), .rgb_data(rgb0),
        .bright_shift(br0), .rgb_led(led0), .busy(busy0), .frame_drop(fd0)
    );

    rgb_strip_driver #(.N_LED(1), .LINES_PER_FRAME(10), .FIRST_LINE(3), .LINE_STEP(180)) dut1 (
        .clk_10MHz(clk), .rst(rst1), .H_sync(hs1), .rgb_data(rgb1),
        .bright_shift(br1), .rgb_led(led1), .busy(busy1), .frame_drop(fd1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int drop0   = 0;
    int drop1   = 0;
    int base;

    always @(negedge clk) begin
        if (fd0 === 1'b1) drop0++;
        if (fd1 === 1'b1) drop1++;
    end

    int          hi_w[96];
    int          lo_w[96];
    logic [95:0] dec_bits;
    bit          dec_to;
    int          first_wt;
    int          bad_bits;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic led_of(input int w);
        return (w == 0) ? led0 : led1;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 0) ? busy0 : busy1;
    endfunction

    // Measure nbits pulses; a pulse is 3 or 6 high samples, and the low run of
    // the last bit extends through the latch until busy falls.
    task automatic decode(input int w, input int nbits);
        int wt, h, l;
        dec_bits = '0;
        dec_to   = 1'b0;
        bad_bits = 0;
        first_wt = -1;
        @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            wt = 0; h = 0; l = 0;
            while (led_of(w) !== 1'b1 && wt < 3000) begin @(negedge clk); wt++; end
            if (led_of(w) !== 1'b1) begin dec_to = 1'b1; return; end
            if (b == 0) first_wt = wt;
            while (led_of(w) === 1'b1 && h < 20) begin @(negedge clk); h++; end
            while (led_of(w) === 1'b0 && busy_of(w) === 1'b1 && l < 1000) begin @(negedge clk); l++; end
            hi_w[b] = h;
            lo_w[b] = l;
            dec_bits[nbits-1-b] = (h == 6);
            if (h != 3 && h != 6) bad_bits++;
            if (b < nbits - 1 && h + l != 12) bad_bits++;
        end
    endtask

    task automatic line(input int w, input logic [23:0] d);
        @(posedge clk); #1;
        if (w == 0) begin rgb0 = d; hs0 = 1'b1; end
        else        begin rgb1 = d; hs1 = 1'b1; end
        repeat (2) @(posedge clk);
        #1;
        if (w == 0) hs0 = 1'b0; else hs1 = 1'b0;
        @(posedge clk);
    endtask

    task automatic frame0(input logic [3:0][23:0] px, input bit chk);
        logic [23:0] d;
        for (int i = 0; i < 750; i++) begin
            d = 24'hA5A5A5;
            if (i == 115) d = px[0];
            if (i == 295) d = px[1];
            if (i == 475) d = px[2];
            if (i == 655) d = px[3];
            line(0, d);
        end
        if (chk) begin
            @(negedge clk);
            check("load_led_low", led0, 1'b0);
            check("load_busy", busy0, 1'b1);
        end
    endtask

    task automatic frame1(input logic [23:0] d3);
        for (int i = 0; i < 10; i++)
            line(1, (i == 3) ? d3 : 24'h5A5A5A);
    endtask

    initial begin
        #(100 * 90000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b1; hs0 = 1'b0; rgb0 = '0; br0 = '0;
        rst1 = 1'b1; hs1 = 1'b0; rgb1 = '0; br1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_led0", led0, 1'b0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_drop0", fd0, 1'b0);
        check("rst_led1", led1, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        rst0 = 1'b0; rst1 = 1'b0;

        // Single frame, four LEDs
        base = drop0;
        frame0({24'h0F0F0F, 24'h0000FF, 24'h00FF00, 24'hFF0000}, 1'b1);
        decode(0, 96);
        check("frame_timeout", dec_to, 1'b0);
        check("first_rise_delay", first_wt, 0);
        check("frame_bits", dec_bits, 96'h00FF00_FF0000_0000FF_0F0F0F);
        check("frame_bit_shapes", bad_bits, 0);
        check("frame_latch_low", lo_w[95], 806);
        check("frame_busy_fall", busy0, 1'b0);
        check("frame_no_drop", drop0 - base, 0);

        // Bit timing
        frame0({24'h000000, 24'h000000, 24'h000000, 24'h800000}, 1'b1);
        decode(0, 96);
        check("timing_bits", dec_bits, {24'h008000, 72'h0});
        check("t0_high", hi_w[0], 3);
        check("t0_low", lo_w[0], 9);
        check("t1_high", hi_w[8], 6);
        check("t1_low", lo_w[8], 6);
        check("timing_periods", bad_bits, 0);
        check("timing_latch_low", lo_w[95], 809);

        // Brightness
        br0 = 3'd4;
        frame0({4{24'hF0F0F0}}, 1'b1);
        decode(0, 96);
        check("bright_bits", dec_bits, {4{24'h0F0F0F}});
        br0 = 3'd0;

        // Reset at bit 40 with the line counter part-way into the next frame
        frame0({4{24'hFFFFFF}}, 1'b1);
        fork
            decode(0, 40);
            repeat (20) line(0, 24'h777777);
        join
        check("pre_rst_timeout", dec_to, 1'b0);
        check("pre_rst_bit40_high", led0, 1'b1);
        rst0 = 1'b1;
        @(negedge clk);
        check("rst_mid_led", led0, 1'b0);
        check("rst_mid_busy", busy0, 1'b0);
        rst0 = 1'b0;
        repeat (30) @(negedge clk);
        check("post_rst_idle_busy", busy0, 1'b0);
        check("post_rst_idle_led", led0, 1'b0);
        frame0({24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0}, 1'b1);
        decode(0, 96);
        check("post_rst_first_rise", first_wt, 0);
        check("post_rst_bits", dec_bits, 96'hB0A0C0_807090_504060_201030);

        // One-LED ten-line instance
        frame1(24'h123456);
        @(negedge clk);
        check("p1_load_led_low", led1, 1'b0);
        check("p1_load_busy", busy1, 1'b1);
        decode(1, 24);
        check("p1_first_rise", first_wt, 0);
        check("p1_bits", dec_bits, {72'h0, 24'h341256});
        check("p1_latch_low", lo_w[23], 809);
        check("p1_busy_fall", busy1, 1'b0);

        // Overrun: second frame ends while the first is still being sent
        base = drop1;
        frame1(24'hAABBCC);
        fork
            decode(1, 24);
            frame1(24'h010203);
        join
        check("ovr_bits", dec_bits, {72'h0, 24'hBBAACC});
        check("ovr_drop_pulse", drop1 - base, 1);
        repeat (50) @(negedge clk);
        check("ovr_no_resend", busy1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
